uart_alu_sequencer: RTL and testbench
=====================================

UART_ALU_SEQUENCER -- requirements
Module: uart_alu_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning UART byte and ALU operand width.
REQ-002 SHALL have parameter ERR_BYTE, default 8'hFF, meaning the byte transmitted for an invalid opcode.
REQ-003 SHALL have parameter TIMEOUT_CLKS, default 2_604_000, meaning the maximum idle clocks between bytes of one command.
REQ-004 SHALL have port i_clk  in  1  system clock, rising-edge active.
REQ-005 SHALL have port i_reset  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_rx_empty  in  1  RX FIFO empty flag.
REQ-007 SHALL have port i_r_data  in  DATA_W  RX FIFO head word, valid while i_rx_empty=0.
REQ-008 SHALL have port o_rd_uart  out  1  RX FIFO pop, one-cycle pulse.
REQ-009 SHALL have port i_tx_full  in  1  TX FIFO full flag.
REQ-010 SHALL have port o_wr_uart  out  1  TX FIFO push, one-cycle pulse.
REQ-011 SHALL have port o_w_data  out  DATA_W  TX FIFO write word.
REQ-012 SHALL have ports o_alu_a, o_alu_b  out  DATA_W  registered ALU operands.
REQ-013 SHALL have port o_alu_op  out  6  registered ALU opcode, taken from the low 6 bits of the opcode byte.
REQ-014 SHALL have port i_alu_result  in  DATA_W  combinational ALU result.
REQ-015 SHALL have port o_busy  out  1  high in every state except S_WAIT_A.
REQ-016 SHALL have port o_err  out  1  one-cycle pulse on invalid opcode or timeout.

Function
REQ-017 SHALL implement the FSM S_WAIT_A -> S_WAIT_B -> S_WAIT_OP -> S_EXEC -> S_SEND -> S_WAIT_A.
REQ-018 In each S_WAIT_x, when i_rx_empty=0 the FSM SHALL latch i_r_data into the target register, pulse o_rd_uart for exactly one cycle, and advance on the same edge.
REQ-019 A pop SHALL never be issued while i_rx_empty=1, and consecutive pops SHALL be separated by at least one cycle of o_rd_uart=0.
REQ-020 S_EXEC SHALL last exactly one cycle and latch the result: i_alu_result for a valid opcode, ERR_BYTE otherwise.
REQ-021 Valid opcodes SHALL be ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SRA 0x03 and SRL 0x02, matched against the full 8-bit byte.
REQ-022 On an invalid opcode, o_err SHALL pulse in the S_EXEC cycle.
REQ-023 S_SEND SHALL hold while i_tx_full=1; on the first cycle with i_tx_full=0 it SHALL pulse o_wr_uart with o_w_data=result and return to S_WAIT_A.
REQ-024 Latency SHALL be exactly 2 cycles from the opcode pop to o_wr_uart when TX is not full.
REQ-025 o_alu_a, o_alu_b and o_alu_op SHALL hold their values until overwritten by the next command.
REQ-026 RX bytes arriving while the FSM is in S_EXEC or S_SEND SHALL remain in the FIFO and SHALL NOT be lost.

Reset
REQ-027 While i_reset=0, the FSM SHALL be in S_WAIT_A; o_rd_uart, o_wr_uart, o_err and o_busy SHALL be 0; and all data registers and o_w_data SHALL be 0.
REQ-028 Reset asserted mid-command SHALL discard the partial command, with no TX write issued.

Configuration
REQ-029 With SEQ_TIMEOUT_EN defined, an idle counter SHALL run in S_WAIT_B and S_WAIT_OP, clear on each pop, and on reaching TIMEOUT_CLKS pulse o_err and return to S_WAIT_A with no TX write.
REQ-030 Without SEQ_TIMEOUT_EN, there SHALL be no counter, and the FSM SHALL wait indefinitely in every S_WAIT_x state.

Structure
REQ-031 Package uart_alu_pkg SHALL hold the opcode localparams, the state enumeration and ERR_BYTE's default.
REQ-032 The idle counter SHALL be sub-module uart_alu_watchdog, instantiated only under SEQ_TIMEOUT_EN.

Verification
REQ-033 Scenario: bytes 0x05, 0x05, 0x20 -> one TX write 0x0A, and exactly three o_rd_uart pulses.
REQ-034 Scenario: bytes 0x05, 0x03, 0x22 -> TX write 0x02; then 0xF0, 0x0F, 0x27 -> TX write 0x00.
REQ-035 Scenario: bytes 0x05, 0x05, 0x3F -> TX write 0xFF, and one o_err pulse.
REQ-036 Scenario: i_tx_full=1 held for 100 cycles around S_SEND -> no o_wr_uart; on release, exactly one write with the correct data.
REQ-037 Scenario: reset pulsed after operand A is popped, then 0x07, 0x01, 0x20 -> TX write 0x08.
REQ-038 Scenario (SEQ_TIMEOUT_EN, TIMEOUT_CLKS=100): byte 0x05, then 150 idle cycles -> o_err pulse and return to S_WAIT_A; then 0x01, 0x02, 0x20 -> TX write 0x03.

Source files
------------

// File: rtl/uart_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_alu_pkg
// Description : Shared opcodes, FSM state encoding and defaults for the
//               UART-fed ALU command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_alu_pkg;

    // Opcode bytes accepted by the sequencer (full 8-bit match)
    localparam logic [7:0] c_OP_ADD = 8'h20;
    localparam logic [7:0] c_OP_SUB = 8'h22;
    localparam logic [7:0] c_OP_AND = 8'h24;
    localparam logic [7:0] c_OP_OR  = 8'h25;
    localparam logic [7:0] c_OP_XOR = 8'h26;
    localparam logic [7:0] c_OP_NOR = 8'h27;
    localparam logic [7:0] c_OP_SRA = 8'h03;
    localparam logic [7:0] c_OP_SRL = 8'h02;

    // Byte returned to the host when the opcode is not recognised
    localparam logic [7:0] c_ERR_BYTE_DEFAULT = 8'hFF;

    typedef enum logic [2:0] {
        S_WAIT_A  = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SEND    = 3'd4
    } state_t;

    // Operand is zero-extended so bytes wider than 8 bits only match when
    // their upper bits are clear.
    function automatic logic is_valid_opcode(input logic [31:0] op);
        case (op)
            32'(c_OP_ADD), 32'(c_OP_SUB), 32'(c_OP_AND), 32'(c_OP_OR),
            32'(c_OP_XOR), 32'(c_OP_NOR), 32'(c_OP_SRA), 32'(c_OP_SRL):
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_alu_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : uart_alu_watchdog
// Description : Inter-byte idle counter. Counts while i_run is high, clears
//               on i_clear or when not running, and flags expiry once
//               TIMEOUT_CLKS idle clocks have accumulated.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_alu_watchdog #(
    parameter int TIMEOUT_CLKS = 2_604_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expired
);

    localparam int                 c_CNT_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CLKS);

    logic [c_CNT_W-1:0] r_count;

    // Idle counter: saturates at the limit until the sequencer leaves
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_clear || !i_run) begin
            r_count <= '0;
        end else if (r_count != c_LIMIT) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_run && (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/uart_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : uart_alu_sequencer
// Description : Pops operand A, operand B and an opcode byte from a UART RX
//               FIFO, drives them to an external ALU, and pushes the result
//               (or ERR_BYTE for an unknown opcode) into the UART TX FIFO.
//               Build option SEQ_TIMEOUT_EN adds an inter-byte watchdog that
//               abandons a partial command after TIMEOUT_CLKS idle clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_alu_sequencer
    import uart_alu_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter logic [DATA_W-1:0] ERR_BYTE     = DATA_W'(c_ERR_BYTE_DEFAULT),
    parameter int                TIMEOUT_CLKS = 2_604_000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx_empty,
    input  logic [DATA_W-1:0] i_r_data,
    output logic              o_rd_uart,
    input  logic              i_tx_full,
    output logic              o_wr_uart,
    output logic [DATA_W-1:0] o_w_data,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [5:0]        o_alu_op,
    input  logic [DATA_W-1:0] i_alu_result,
    output logic              o_busy,
    output logic              o_err
);

    if (DATA_W < 8) begin : g_bad_data_w
        $error("uart_alu_sequencer: DATA_W must be at least 8");
    end
    if (TIMEOUT_CLKS < 1) begin : g_bad_timeout
        $error("uart_alu_sequencer: TIMEOUT_CLKS must be at least 1");
    end

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_op;
    logic [DATA_W-1:0] r_result;
    logic              r_pop_gap;
    logic              w_rx_ok;
    logic              w_pop;
    logic              w_push;
    logic              w_err;
    logic              w_op_valid;
    logic              w_timeout;

    // A pop is blocked in the cycle after a pop so the FIFO head can update
    assign w_rx_ok    = !i_rx_empty && !r_pop_gap;
    assign w_op_valid = is_valid_opcode(32'(r_op));

`ifdef SEQ_TIMEOUT_EN
    logic w_idle_run;
    logic w_expired;

    assign w_idle_run = (r_state == S_WAIT_B) || (r_state == S_WAIT_OP);

    uart_alu_watchdog #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_run     (w_idle_run),
        .i_clear   (w_pop),
        .o_expired (w_expired)
    );

    assign w_timeout = w_expired;
`else
    assign w_timeout = 1'b0;
`endif

    // State register; the pop gap flag resets high so no pop occurs in reset
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= S_WAIT_A;
            r_pop_gap <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_pop_gap <= w_pop;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_push       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_WAIT_A: begin
                if (w_rx_ok) begin
                    w_pop        = 1'b1;
                    w_state_next = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (w_rx_ok) begin
                    w_pop        = 1'b1;
                    w_state_next = S_WAIT_OP;
                end else if (w_timeout) begin
                    w_err        = 1'b1;
                    w_state_next = S_WAIT_A;
                end
            end
            S_WAIT_OP: begin
                if (w_rx_ok) begin
                    w_pop        = 1'b1;
                    w_state_next = S_EXEC;
                end else if (w_timeout) begin
                    w_err        = 1'b1;
                    w_state_next = S_WAIT_A;
                end
            end
            S_EXEC: begin
                w_err        = !w_op_valid;
                w_state_next = S_SEND;
            end
            S_SEND: begin
                if (!i_tx_full) begin
                    w_push       = 1'b1;
                    w_state_next = S_WAIT_A;
                end
            end
            default: begin
                w_state_next = S_WAIT_A;
            end
        endcase
    end

    // Operand capture on each pop and result capture in the execute cycle
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
        end else begin
            if (w_pop && (r_state == S_WAIT_A)) begin
                r_a <= i_r_data;
            end
            if (w_pop && (r_state == S_WAIT_B)) begin
                r_b <= i_r_data;
            end
            if (w_pop && (r_state == S_WAIT_OP)) begin
                r_op <= i_r_data;
            end
            if (r_state == S_EXEC) begin
                r_result <= w_op_valid ? i_alu_result : ERR_BYTE;
            end
        end
    end

    assign o_rd_uart = w_pop;
    assign o_wr_uart = w_push;
    assign o_w_data  = r_result;
    assign o_alu_a   = r_a;
    assign o_alu_b   = r_b;
    assign o_alu_op  = r_op[5:0];
    assign o_busy    = (r_state != S_WAIT_A);
    assign o_err     = w_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_alu_sequencer
// Description : Directed bench for uart_alu_sequencer with an RX FIFO model,
//               a reference ALU and pulse monitors. Exercises the timeout
//               scenario when SEQ_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_result;
    logic       busy;
    logic       err;

    always #5 clk = ~clk;

    uart_alu_sequencer #(
        .DATA_W       (8),
        .ERR_BYTE     (8'hFF),
        .TIMEOUT_CLKS (100)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_rx_empty   (rx_empty),
        .i_r_data     (r_data),
        .o_rd_uart    (rd_uart),
        .i_tx_full    (tx_full),
        .o_wr_uart    (wr_uart),
        .o_w_data     (w_data),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .i_alu_result (alu_result),
        .o_busy       (busy),
        .o_err        (err)
    );

    // Reference ALU driven by the registered operands
    always_comb begin
        alu_result = 8'h5A;
        case (alu_op)
            6'h20: alu_result = alu_a + alu_b;
            6'h22: alu_result = alu_a - alu_b;
            6'h24: alu_result = alu_a & alu_b;
            6'h25: alu_result = alu_a | alu_b;
            6'h26: alu_result = alu_a ^ alu_b;
            6'h27: alu_result = ~(alu_a | alu_b);
            6'h03: alu_result = 8'($signed(alu_a) >>> alu_b);
            6'h02: alu_result = alu_a >> alu_b;
            default: alu_result = 8'h5A;
        endcase
    end

    // RX FIFO model: bytes loaded by the stimulus, popped on o_rd_uart
    logic [7:0] stim [0:63];
    int         n_loaded = 0;
    int         rd_ptr   = 0;

    always @(posedge clk) begin
        if (rd_uart && (rd_ptr < n_loaded)) begin
            rd_ptr <= rd_ptr + 1;
        end
    end

    assign rx_empty = (rd_ptr >= n_loaded);
    assign r_data   = stim[rd_ptr % 64];

    // Pulse monitors sampled on the falling edge
    int         cyc = 0;
    int         rd_cnt = 0;
    int         wr_cnt = 0;
    int         err_cnt = 0;
    int         viol = 0;
    int         last_pop_cyc = 0;
    int         wr_cyc = 0;
    logic       prev_rd = 1'b0;
    logic [7:0] wr_log [0:63];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rd_uart) begin
            rd_cnt = rd_cnt + 1;
            last_pop_cyc = cyc;
            if (rx_empty) viol = viol + 1;
            if (prev_rd) viol = viol + 1;
        end
        prev_rd = rd_uart;
        if (wr_uart) begin
            wr_log[wr_cnt % 64] = w_data;
            wr_cnt = wr_cnt + 1;
            wr_cyc = cyc;
            if (tx_full) viol = viol + 1;
        end
        if (err) err_cnt = err_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        stim[n_loaded % 64] = b;
        n_loaded = n_loaded + 1;
    endtask

    task automatic wait_wr(input int target, input int budget);
        int k = 0;
        while ((wr_cnt < target) && (k < budget)) begin
            step(1);
            k++;
        end
    endtask

    task automatic wait_rd(input int target, input int budget);
        int k = 0;
        while ((rd_cnt < target) && (k < budget)) begin
            step(1);
            k++;
        end
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp_data, input int exp_err);
        int base_rd  = rd_cnt;
        int base_wr  = wr_cnt;
        int base_err = err_cnt;
        push(a);
        push(b);
        push(op);
        wait_wr(base_wr + 1, 40);
        step(2);
        check({tag, "_wr_count"}, wr_cnt - base_wr, 1);
        check({tag, "_data"}, wr_log[base_wr % 64], exp_data);
        check({tag, "_pops"}, rd_cnt - base_rd, 3);
        check({tag, "_err"}, err_cnt - base_err, exp_err);
    endtask

    int base_rd;
    int base_wr;
    int base_err;

    initial begin
        rst_n   = 1'b0;
        tx_full = 1'b0;
        step(3);
        check("rst_busy", busy, 0);
        check("rst_rd", rd_uart, 0);
        check("rst_wr", wr_uart, 0);
        check("rst_err", err, 0);
        check("rst_wdata", w_data, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_op, 0);
        rst_n = 1'b1;
        step(2);

        // 5 + 5
        run_cmd("add", 8'h05, 8'h05, 8'h20, 8'h0A, 0);
        check("add_latency", wr_cyc - last_pop_cyc, 2);
        check("add_hold_a", alu_a, 8'h05);
        check("add_hold_b", alu_b, 8'h05);
        check("add_hold_op", alu_op, 6'h20);
        check("add_idle", busy, 0);

        // Two commands queued back to back: SUB then NOR
        base_rd = rd_cnt;
        base_wr = wr_cnt;
        push(8'h05); push(8'h03); push(8'h22);
        push(8'hF0); push(8'h0F); push(8'h27);
        wait_wr(base_wr + 2, 80);
        step(2);
        check("b2b_wr_count", wr_cnt - base_wr, 2);
        check("b2b_sub_data", wr_log[base_wr % 64], 8'h02);
        check("b2b_nor_data", wr_log[(base_wr + 1) % 64], 8'h00);
        check("b2b_pops", rd_cnt - base_rd, 6);
        check("b2b_latency", wr_cyc - last_pop_cyc, 2);

        // Invalid opcodes, including one whose low 6 bits look like ADD
        run_cmd("bad3f", 8'h05, 8'h05, 8'h3F, 8'hFF, 1);
        check("bad3f_op", alu_op, 6'h3F);
        run_cmd("bade0", 8'h05, 8'h05, 8'hE0, 8'hFF, 1);
        check("bade0_op", alu_op, 6'h20);

        // Shifts and logic ops
        run_cmd("sra", 8'h80, 8'h02, 8'h03, 8'hE0, 0);
        run_cmd("srl", 8'h80, 8'h02, 8'h02, 8'h20, 0);
        run_cmd("xor", 8'hA5, 8'h0F, 8'h26, 8'hAA, 0);

        // TX back-pressure
        tx_full  = 1'b1;
        base_rd  = rd_cnt;
        base_wr  = wr_cnt;
        push(8'h0A); push(8'h06); push(8'h24);
        step(100);
        check("full_no_wr", wr_cnt - base_wr, 0);
        check("full_busy", busy, 1);
        check("full_pops", rd_cnt - base_rd, 3);
        tx_full = 1'b0;
        wait_wr(base_wr + 1, 10);
        step(5);
        check("full_wr_count", wr_cnt - base_wr, 1);
        check("full_data", wr_log[base_wr % 64], 8'h02);

        // Reset after operand A discards the partial command
        base_wr = wr_cnt;
        base_rd = rd_cnt;
        push(8'h09);
        wait_rd(base_rd + 1, 20);
        step(1);
        rst_n = 1'b0;
        step(2);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_alu_a", alu_a, 0);
        rst_n = 1'b1;
        step(1);
        run_cmd("post_rst", 8'h07, 8'h01, 8'h20, 8'h08, 0);
        check("post_rst_total_wr", wr_cnt - base_wr, 1);

        // Abandoned command followed by idle time
        base_wr  = wr_cnt;
        base_rd  = rd_cnt;
        base_err = err_cnt;
        push(8'h05);
        wait_rd(base_rd + 1, 20);
        step(150);
`ifdef SEQ_TIMEOUT_EN
        check("to_err", err_cnt - base_err, 1);
        check("to_idle", busy, 0);
        check("to_no_wr", wr_cnt - base_wr, 0);
        run_cmd("to_after", 8'h01, 8'h02, 8'h20, 8'h03, 0);
`else
        check("nto_err", err_cnt - base_err, 0);
        check("nto_busy", busy, 1);
        check("nto_no_wr", wr_cnt - base_wr, 0);
        push(8'h01);
        push(8'h20);
        wait_wr(base_wr + 1, 40);
        step(2);
        check("nto_wr_count", wr_cnt - base_wr, 1);
        check("nto_data", wr_log[base_wr % 64], 8'h06);
`endif

        check("protocol_violations", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
